// File: rtl/fetch_pipe_unit.sv
// fetch_pipe_unit: fetch-to-decode register with 2-entry skid queue, redirect squash and fetch backpressure; FETCH_PIPE_BYPASS_EN enables 1-cycle empty-queue bypass
module fetch_pipe_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    stall_mem_wb,
    input  logic                    req_issue,
    input  logic                    inst_valid_fetch,
    input  logic [DATA_WIDTH-1:0]   instruction_fetch,
    input  logic [ADDRESS_BITS-1:0] PC_fetch,
    input  logic [1:0]              next_PC_select_execute,
    input  logic                    branch_execute,
    output logic [DATA_WIDTH-1:0]   instruction_decode,
    output logic [ADDRESS_BITS-1:0] PC_decode,
    output logic                    valid_decode,
    output logic                    fetch_hold,
    output logic                    queue_overflow
);
    localparam int EW = DATA_WIDTH + ADDRESS_BITS;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} count_t;

    count_t                  count, count_n;
    logic [1:0]              outstanding, outstanding_n, drop, drop_n, level;
    logic [EW-1:0]           q [2];
    logic [EW-1:0]           q_n [2];
    logic                    flush, advance, accept, deq, byp, enq, room, resp, overflow_n, valid_n;
    logic [DATA_WIDTH-1:0]   inst_n;
    logic [ADDRESS_BITS-1:0] pc_n;

    always_comb begin
        flush   = next_PC_select_execute[1] | ((next_PC_select_execute == 2'b01) & branch_execute);
        advance = !flush && !(stall || stall_mem_wb);
        accept  = inst_valid_fetch && drop == 2'd0 && !flush;
        deq     = advance && count != EMPTY;
`ifdef FETCH_PIPE_BYPASS_EN
        byp     = advance && count == EMPTY && accept;
`else
        byp     = 1'b0;
`endif
        enq     = accept && !byp;
        // occupancy after this cycle's dequeue decides where (and whether) the response lands
        level   = count - {1'b0, deq};
        room    = level != 2'd2;
        q_n     = q;
        if (deq) q_n[0] = q[1];
        if (enq && room) q_n[level[0]] = {instruction_fetch, PC_fetch};
        count_n       = flush ? EMPTY : count_t'(level + {1'b0, enq && room});
        overflow_n    = queue_overflow || (enq && !room);
        resp          = inst_valid_fetch && outstanding != 2'd0;
        outstanding_n = outstanding + {1'b0, req_issue} - {1'b0, resp};
        // a request issued in the flush cycle targets the new PC, so it is not counted for dropping
        drop_n  = flush ? outstanding - {1'b0, resp} : drop - {1'b0, inst_valid_fetch && drop != 2'd0};
        valid_n = flush ? 1'b0 : (deq || byp) ? 1'b1 : advance ? 1'b0 : valid_decode;
        inst_n  = (flush || (advance && !deq && !byp)) ? NOP
                : deq ? q[0][EW-1:ADDRESS_BITS] : byp ? instruction_fetch : instruction_decode;
        pc_n    = (flush || (advance && !deq && !byp)) ? '0
                : deq ? q[0][ADDRESS_BITS-1:0] : byp ? PC_fetch : PC_decode;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count              <= EMPTY;
            outstanding        <= '0;
            drop               <= '0;
            q[0]               <= '0;
            q[1]               <= '0;
            queue_overflow     <= 1'b0;
            instruction_decode <= NOP;
            PC_decode          <= '0;
            valid_decode       <= 1'b0;
        end else begin
            count              <= count_n;
            outstanding        <= outstanding_n;
            drop               <= drop_n;
            q[0]               <= q_n[0];
            q[1]               <= q_n[1];
            queue_overflow     <= overflow_n;
            instruction_decode <= inst_n;
            PC_decode          <= pc_n;
            valid_decode       <= valid_n;
        end
    end

    assign fetch_hold = ({1'b0, count} + {1'b0, outstanding}) >= 3'd2;
endmodule

// File: tb/tb_fetch_pipe_unit.sv
// tb_fetch_pipe_unit: scoreboard bench for fetch_pipe_unit in either bypass build
module tb_fetch_pipe_unit;
`ifdef FETCH_PIPE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, stall_mem_wb = 1'b0, req_issue = 1'b0, inst_valid_fetch = 1'b0;
    logic [31:0] instruction_fetch = '0;
    logic [19:0] PC_fetch = '0;
    logic [1:0]  next_PC_select_execute = '0;
    logic        branch_execute = 1'b0;
    logic [31:0] instruction_decode;
    logic [19:0] PC_decode;
    logic        valid_decode, fetch_hold, queue_overflow;

    int checks = 0;
    int errors = 0;
    logic [51:0] sb [$];

    fetch_pipe_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset), .stall(stall), .stall_mem_wb(stall_mem_wb),
        .req_issue(req_issue), .inst_valid_fetch(inst_valid_fetch),
        .instruction_fetch(instruction_fetch), .PC_fetch(PC_fetch),
        .next_PC_select_execute(next_PC_select_execute), .branch_execute(branch_execute),
        .instruction_decode(instruction_decode), .PC_decode(PC_decode), .valid_decode(valid_decode),
        .fetch_hold(fetch_hold), .queue_overflow(queue_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, expect-push accepted responses, then pop on every advancing edge
    task automatic step(input bit req, input bit vld, input logic [31:0] ins, input logic [19:0] pc,
                        input bit keep, input bit stl, input bit smw, input logic [1:0] sel, input bit br);
        logic [51:0] e;
        bit fl, adv;
        req_issue = req; inst_valid_fetch = vld; instruction_fetch = ins; PC_fetch = pc;
        stall = stl; stall_mem_wb = smw; next_PC_select_execute = sel; branch_execute = br;
        fl  = sel == 2'b11 || sel == 2'b10 || (sel == 2'b01 && br);
        adv = !fl && !stl && !smw;
        if (fl) sb.delete();
        if (keep) sb.push_back({ins, pc});
        @(posedge clock);
        #1;
        if (adv && valid_decode) begin
            if (sb.size() == 0) check("sb_extra", 64'(valid_decode), 64'd0);
            else begin
                e = sb.pop_front();
                check("sb_inst", 64'(instruction_decode), 64'(e[51:20]));
                check("sb_pc", 64'(PC_decode), 64'(e[19:0]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_inst"}, 64'(instruction_decode), 64'h13);
        check({tag, "_pc"}, 64'(PC_decode), 64'd0);
        check({tag, "_valid"}, 64'(valid_decode), 64'd0);
        check({tag, "_ovf"}, 64'(queue_overflow), 64'd0);
        check({tag, "_hold"}, 64'(fetch_hold), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset_checks("rst");
        reset = 1'b1;
        idle(1);
        // back-to-back responses, no stall
        step(1, 0, '0, '0, 0, 0, 0, 2'b00, 0);
        step(1, 1, 32'h00500093, 20'h0, 1, 0, 0, 2'b00, 0);
        check("lat_first", 64'(valid_decode), 64'(BYP));
        step(0, 1, 32'h00100113, 20'h4, 1, 0, 0, 2'b00, 0);
        check("lat_second", 64'(valid_decode), 64'd1);
        idle(3);
        // stall while two responses arrive
        step(1, 0, '0, '0, 0, 1, 0, 2'b00, 0);
        step(1, 1, 32'h00A00193, 20'h8, 1, 1, 0, 2'b00, 0);
        step(0, 1, 32'h00B00213, 20'hC, 1, 0, 1, 2'b00, 0);
        check("stall_hold_full", 64'(fetch_hold), 64'd1);
        step(0, 0, '0, '0, 0, 1, 0, 2'b00, 0);
        check("stall_out_inst", 64'(instruction_decode), 64'h13);
        check("stall_out_valid", 64'(valid_decode), 64'd0);
        check("stall_full_hold", 64'(fetch_hold), 64'd1);
        step(0, 0, '0, '0, 0, 0, 0, 2'b00, 0);
        check("release_v1", 64'(valid_decode), 64'd1);
        step(0, 0, '0, '0, 0, 0, 0, 2'b00, 0);
        check("release_v2", 64'(valid_decode), 64'd1);
        step(0, 0, '0, '0, 0, 0, 0, 2'b00, 0);
        check("release_empty", 64'(valid_decode), 64'd0);
        // flush with two queued and one in flight, coincident with stall
        step(1, 0, '0, '0, 0, 1, 0, 2'b00, 0);
        step(1, 1, 32'h00D00313, 20'h10, 1, 1, 0, 2'b00, 0);
        step(1, 1, 32'h00E00393, 20'h14, 1, 1, 0, 2'b00, 0);
        check("pre_flush_hold", 64'(fetch_hold), 64'd1);
        step(0, 0, '0, '0, 0, 1, 0, 2'b10, 0);
        check("flush_inst", 64'(instruction_decode), 64'h13);
        check("flush_pc", 64'(PC_decode), 64'd0);
        check("flush_valid", 64'(valid_decode), 64'd0);
        check("flush_hold", 64'(fetch_hold), 64'd0);
        step(1, 1, 32'hDEADBEEF, 20'h18, 0, 0, 0, 2'b00, 0);
        check("drop_valid", 64'(valid_decode), 64'd0);
        step(0, 1, 32'h00C00293, 20'h100, 1, 0, 0, 2'b00, 0);
        idle(2);
        // select 01 without taken branch is not a redirect
        step(1, 0, '0, '0, 0, 0, 0, 2'b01, 0);
        step(0, 1, 32'h00F00413, 20'h104, 1, 0, 0, 2'b01, 0);
        check("nobr_hold", 64'(fetch_hold), 64'd0);
        idle(2);
        check("nobr_ovf", 64'(queue_overflow), 64'd0);
        // overflow: third response into a full stalled queue
        step(1, 0, '0, '0, 0, 1, 0, 2'b00, 0);
        step(1, 1, 32'h01000493, 20'h200, 1, 1, 0, 2'b00, 0);
        step(1, 1, 32'h01100513, 20'h204, 1, 1, 0, 2'b00, 0);
        step(0, 1, 32'h01200593, 20'h208, 0, 1, 0, 2'b00, 0);
        check("ovf_set", 64'(queue_overflow), 64'd1);
        check("ovf_hold", 64'(fetch_hold), 64'd1);
        idle(3);
        check("ovf_sticky", 64'(queue_overflow), 64'd1);
        // asynchronous reset mid-stall with a full queue
        step(1, 0, '0, '0, 0, 1, 0, 2'b00, 0);
        step(1, 1, 32'h01300613, 20'h300, 1, 1, 0, 2'b00, 0);
        step(0, 1, 32'h01400693, 20'h304, 1, 1, 0, 2'b00, 0);
        check("pre_rst_hold", 64'(fetch_hold), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        reset_checks("async_rst");
        sb.delete();
        idle(1);
        reset = 1'b1;
        idle(1);
        step(1, 0, '0, '0, 0, 0, 0, 2'b00, 0);
        step(0, 1, 32'h01500713, 20'h400, 1, 0, 0, 2'b00, 0);
        idle(3);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pipe_unit.md
# fetch_pipe_unit

Fetch-to-decode pipeline register for the seven-stage core with an integrated 2-entry instruction skid queue. It accepts I-cache responses, holds them across decode-side stalls, squashes wrong-path instructions on redirects resolved in execute, and drives the decode stage. It backpressures fetch so that no in-flight response is ever lost.

## Interface
- DATA_WIDTH, 32, instruction/data width
- ADDRESS_BITS, 20, PC width

- clock  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold decode input (hazard or later-stage stall)
- stall_mem_wb  in  1  stall originates in memory/writeback; treated as a hold here
- req_issue  in  1  fetch issued an I-cache request this cycle
- inst_valid_fetch  in  1  I-cache response valid this cycle (1-cycle pulse)
- instruction_fetch  in  DATA_WIDTH  response instruction
- PC_fetch  in  ADDRESS_BITS  PC of response
- next_PC_select_execute  in  2  execute-stage next-PC select
- branch_execute  in  1  branch taken in execute
- instruction_decode  out  DATA_WIDTH  instruction to decode
- PC_decode  out  ADDRESS_BITS  PC to decode
- valid_decode  out  1  instruction_decode is real (not inserted NOP)
- fetch_hold  out  1  fetch must not assert req_issue
- queue_overflow  out  1  sticky protocol-violation flag

## Operation
- flush = (next_PC_select_execute==2'b11) | (==2'b10) | ((==2'b01) & branch_execute).
- Priority per cycle: reset > flush > stall > advance.
- Queue: 2 entries of {instruction, PC}, FIFO order; occupancy count 0..2 (states EMPTY, ONE, TWO).
- outstanding: 0..2 requests in flight; +1 on req_issue, -1 on inst_valid_fetch, both same cycle = unchanged.
- drop: 0..2 responses to discard. On flush, drop <= outstanding after the current cycle's response is accounted, excluding any req_issue in the flush cycle (that request targets the redirected PC and is kept).
- Response with drop>0: discarded, drop decrements, no enqueue.
- Accepted response: enqueued at tail; if queue full, response is lost and queue_overflow sets (cleared only by reset).
- Advance (no flush, no stall): output register loads queue head (dequeue) if count>0; else loads accepted same-cycle response if bypass is compiled in; else loads NOP 32'h00000013, PC 0, valid_decode 0.
- Stall: output register holds; queue may still enqueue.
- Flush: output register <= NOP, PC 0, valid_decode 0; queue emptied; same-cycle response discarded.
- fetch_hold = (count + outstanding) >= 2, combinational from registered state only.

## Timing
- Reset values: instruction_decode 32'h00000013, PC_decode 0, valid_decode 0, queue_overflow 0; count, outstanding and drop 0; fetch_hold 0.
- Reset is asynchronous; it takes effect mid-operation immediately, discarding queued and in-flight state.
- Latency with empty queue and no stall: response at cycle t appears at decode at t+1 with bypass, and at t+2 without bypass.
- Stall release: the queue head appears at decode on the first non-stall edge, one entry per cycle thereafter.
- Simultaneous enqueue and dequeue at count 2 is legal: the head leaves and the tail is written, so no overflow.
- Flush coincident with stall: the flush wins.

## Configuration
- FETCH_PIPE_BYPASS_EN defined: when the queue is empty and not stalled, a same-cycle accepted response goes directly to the output register, giving 1-cycle latency.
- FETCH_PIPE_BYPASS_EN undefined: every response is enqueued first, giving 2-cycle minimum latency. The queue and backpressure are otherwise identical.

## Test plan
- Reset release, then responses 0x00500093 at PC 0x0 and 0x00100113 at PC 0x4 on consecutive cycles, no stall -> decode sees them in order with valid_decode=1, at t+1/t+2 (bypass) or t+2/t+3.
- Stall 4 cycles while 2 responses arrive -> output holds, count=2, fetch_hold=1; on release, both appear in order on consecutive cycles.
- Flush via next_PC_select_execute=2'b10 with count=2 and outstanding=1 -> output NOP/valid 0, queue empty; next response dropped; following response (new target) accepted.
- next_PC_select_execute=2'b01 with branch_execute=0 -> no flush, flow unaffected.
- Inject response while count=2 and stalled -> queue_overflow=1 and stays set until reset.
- Assert reset low mid-stall with full queue -> all outputs return to reset values asynchronously.
